// File: rtl/cvxif_mac_simd_unit.sv
// Pipelined 4x8 / 2x16 SIMD multiply-accumulate for CV-X-IF: rd = rs3 + sum(rs1[i]*rs2[i]).
// Results return in order through a credit-gated FWFT FIFO; define CVXIF_MAC_SAT_EN to clamp results.
module cvxif_mac_simd_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ID_WIDTH    = 3,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ID_WIDTH-1:0] req_id_i,
  input  logic [4:0]          req_rd_i,
  input  logic [1:0]          req_mode_i,
  input  logic [XLEN-1:0]     req_rs1_i,
  input  logic [XLEN-1:0]     req_rs2_i,
  input  logic [XLEN-1:0]     req_rs3_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [ID_WIDTH-1:0] res_id_o,
  output logic [4:0]          res_rd_o,
  output logic [XLEN-1:0]     res_data_o,
  output logic                busy_o
);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENTRY_W = XLEN + ID_WIDTH + 5;

  logic [CNT_W-1:0] credit_cnt_reg;
  logic             accept;
  logic             pop;

  // Credits cover pipeline plus FIFO, so the pipeline never needs to stall.
  assign req_ready_o = (credit_cnt_reg < CNT_W'(FIFO_DEPTH));
  assign accept      = req_valid_i && req_ready_o && !flush_i;
  assign busy_o      = (credit_cnt_reg != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               credit_cnt_reg <= '0;
    else if (flush_i)          credit_cnt_reg <= '0;
    else if (accept && !pop)   credit_cnt_reg <= credit_cnt_reg + CNT_W'(1);
    else if (!accept && pop)   credit_cnt_reg <= credit_cnt_reg - CNT_W'(1);
  end

  logic                s0_vld_reg;
  logic [ID_WIDTH-1:0] s0_id_reg;
  logic [4:0]          s0_rd_reg;
  logic [1:0]          s0_mode_reg;
  logic [XLEN-1:0]     s0_rs1_reg, s0_rs2_reg, s0_rs3_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) s0_vld_reg <= 1'b0;
    else         s0_vld_reg <= accept;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      s0_id_reg   <= req_id_i;
      s0_rd_reg   <= req_rd_i;
      s0_mode_reg <= req_mode_i;
      s0_rs1_reg  <= req_rs1_i;
      s0_rs2_reg  <= req_rs2_i;
      s0_rs3_reg  <= req_rs3_i;
    end
  end

  // Every lane is a 17x17 signed multiply; unsigned operands are zero-extended into it.
  logic signed [33:0] prod [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [15:0]        a_wide, b_wide;
    logic [7:0]         a_byte, b_byte;
    logic signed [16:0] a_ext, b_ext;
    logic signed [33:0] a_34, b_34;

    if (gi < 2) begin : g_wide
      assign a_wide = s0_rs1_reg[16*gi +: 16];
      assign b_wide = s0_rs2_reg[16*gi +: 16];
    end else begin : g_unused_wide
      assign a_wide = '0;
      assign b_wide = '0;
    end
    assign a_byte = s0_rs1_reg[8*gi +: 8];
    assign b_byte = s0_rs2_reg[8*gi +: 8];

    always_comb begin
      a_ext = '0;
      b_ext = '0;
      if (s0_mode_reg[0]) begin
        a_ext = {s0_mode_reg[1] & a_wide[15], a_wide};
        b_ext = {s0_mode_reg[1] & b_wide[15], b_wide};
      end else begin
        a_ext = {{9{s0_mode_reg[1] & a_byte[7]}}, a_byte};
        b_ext = {{9{s0_mode_reg[1] & b_byte[7]}}, b_byte};
      end
    end

    assign a_34     = a_ext;
    assign b_34     = b_ext;
    assign prod[gi] = a_34 * b_34;
  end

  logic signed [33:0] rs3_ext;
  logic signed [33:0] sum;
  logic [XLEN-1:0]    result;

  assign rs3_ext = {{2{s0_mode_reg[1] & s0_rs3_reg[XLEN-1]}}, s0_rs3_reg};
  assign sum     = rs3_ext + prod[0] + prod[1] + prod[2] + prod[3];

`ifdef CVXIF_MAC_SAT_EN
  always_comb begin
    result = sum[31:0];
    if (s0_mode_reg[1]) begin
      if (!sum[33] && (sum[32:31] != 2'b00))     result = 32'h7FFF_FFFF;
      else if (sum[33] && (sum[32:31] != 2'b11)) result = 32'h8000_0000;
    end else if (sum[33:32] != 2'b00) begin
      result = 32'hFFFF_FFFF;
    end
  end
`else
  logic unused_sum_msbs;
  assign unused_sum_msbs = ^sum[33:32];
  assign result          = sum[31:0];
`endif

  logic                stage_vld  [PIPE_STAGES];
  logic [ID_WIDTH-1:0] stage_id   [PIPE_STAGES];
  logic [4:0]          stage_rd   [PIPE_STAGES];
  logic [XLEN-1:0]     stage_data [PIPE_STAGES];

  assign stage_vld[0]  = s0_vld_reg;
  assign stage_id[0]   = s0_id_reg;
  assign stage_rd[0]   = s0_rd_reg;
  assign stage_data[0] = result;

  for (genvar gi = 1; gi < PIPE_STAGES; gi++) begin : g_stage
    logic                vld_reg;
    logic [ID_WIDTH-1:0] id_reg;
    logic [4:0]          rd_reg;
    logic [XLEN-1:0]     data_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) vld_reg <= 1'b0;
      else         vld_reg <= stage_vld[gi-1] && !flush_i;
    end

    always_ff @(posedge clk_i) begin
      id_reg   <= stage_id[gi-1];
      rd_reg   <= stage_rd[gi-1];
      data_reg <= stage_data[gi-1];
    end

    assign stage_vld[gi]  = vld_reg;
    assign stage_id[gi]   = id_reg;
    assign stage_rd[gi]   = rd_reg;
    assign stage_data[gi] = data_reg;
  end

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   fifo_cnt_reg;
  logic [ENTRY_W-1:0] head;
  logic               wr_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_en       = stage_vld[PIPE_STAGES-1] && !flush_i;
  assign res_valid_o = (fifo_cnt_reg != '0);
  assign pop         = res_valid_o && res_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else if (flush_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)   rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (wr_en && !pop)      fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
      else if (!wr_en && pop) fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= {stage_id[PIPE_STAGES-1], stage_rd[PIPE_STAGES-1],
                               stage_data[PIPE_STAGES-1]};
    end
  end

  // Outputs are forced to zero while empty so stale entries never show.
  assign head       = fifo_mem[rd_ptr_reg];
  assign res_id_o   = res_valid_o ? head[ENTRY_W-1 -: ID_WIDTH] : '0;
  assign res_rd_o   = res_valid_o ? head[XLEN +: 5] : '0;
  assign res_data_o = res_valid_o ? head[XLEN-1:0] : '0;

endmodule

// File: tb/tb_cvxif_mac_simd_unit.sv
// Directed testbench for cvxif_mac_simd_unit: arithmetic modes, latency, backpressure, flush, reset.
// Expected results follow CVXIF_MAC_SAT_EN when it is defined.
module tb_cvxif_mac_simd_unit;
  localparam int PIPE_STAGES = 2;
  localparam int FIFO_DEPTH  = 2;

  logic        clk_i, rst_ni, flush_i;
  logic        req_valid_i, req_ready_o;
  logic [2:0]  req_id_i;
  logic [4:0]  req_rd_i;
  logic [1:0]  req_mode_i;
  logic [31:0] req_rs1_i, req_rs2_i, req_rs3_i;
  logic        res_valid_o, res_ready_i;
  logic [2:0]  res_id_o;
  logic [4:0]  res_rd_o;
  logic [31:0] res_data_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] acc_q[$];
  logic [31:0] pop_id_q[$];
  logic [31:0] pop_data_q[$];

  cvxif_mac_simd_unit #(
    .XLEN(32), .ID_WIDTH(3), .PIPE_STAGES(PIPE_STAGES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_id_i(req_id_i), .req_rd_i(req_rd_i), .req_mode_i(req_mode_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rs3_i(req_rs3_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_id_o(res_id_o), .res_rd_o(res_rd_o), .res_data_o(res_data_o),
    .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Handshakes are observed mid-cycle, where inputs and outputs are settled.
  always @(negedge clk_i) begin
    if (rst_ni && res_valid_o && res_ready_i) begin
      pop_id_q.push_back(32'(res_id_o));
      pop_data_q.push_back(res_data_o);
    end
    if (rst_ni && req_valid_i && req_ready_o && !flush_i) acc_q.push_back(32'(req_id_i));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] id, input logic [4:0] rd, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    req_id_i   = id;
    req_rd_i   = rd;
    req_mode_i = mode;
    req_rs1_i  = a;
    req_rs2_i  = b;
    req_rs3_i  = c;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_valid"}, 32'(res_valid_o), 32'd0);
    check({tag, "_res_id"},    32'(res_id_o),    32'd0);
    check({tag, "_res_rd"},    32'(res_rd_o),    32'd0);
    check({tag, "_res_data"},  res_data_o,       32'd0);
    check({tag, "_busy"},      32'(busy_o),      32'd0);
    check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  task automatic run_one(input string tag, input logic [2:0] id, input logic [4:0] rd,
                         input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] exp);
    int lat;
    drive(id, rd, mode, a, b, c);
    req_valid_i = 1'b1;
    res_ready_i = 1'b1;
    check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 1'b0;
    lat = 0;
    while (!res_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(PIPE_STAGES));
    check({tag, "_data"}, res_data_o, exp);
    check({tag, "_id"}, 32'(res_id_o), 32'(id));
    check({tag, "_rd"}, 32'(res_rd_o), 32'(rd));
    $display("txn %s id=%0d rd=%0d data=0x%08h latency=%0d", tag, res_id_o, res_rd_o, res_data_o, lat);
    tick();
    check({tag, "_drained"}, 32'(busy_o), 32'd0);
  endtask

  logic [31:0] exp_s16, exp_u16, exp_s16n;

  initial begin
`ifdef CVXIF_MAC_SAT_EN
    exp_s16  = 32'h7FFF_FFFF;
    exp_u16  = 32'hFFFF_FFFF;
    exp_s16n = 32'h8000_0000;
`else
    exp_s16  = 32'hFFFE_0001;
    exp_u16  = 32'hFFFC_0001;
    exp_s16n = 32'h0001_0000;
`endif
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; res_ready_i = 1'b0;
    drive(3'd0, 5'd0, 2'b00, 32'd0, 32'd0, 32'd0);
    repeat (3) tick();
    rst_ni = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick();

    // Arithmetic modes and wrap/clamp boundaries.
    run_one("u8",   3'd1, 5'd5,  2'b00, 32'h0102_0304, 32'h0506_0708, 32'h0000_0010, 32'h0000_0056);
    run_one("s8",   3'd2, 5'd6,  2'b10, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0000, 32'hFFFF_FFFC);
    run_one("u8b",  3'd3, 5'd7,  2'b00, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0000, 32'h0000_03FC);
    run_one("s16",  3'd4, 5'd8,  2'b11, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_FFFF, exp_s16);
    run_one("u16",  3'd5, 5'd9,  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_u16);
    run_one("s16n", 3'd6, 5'd10, 2'b11, 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_0000, exp_s16n);

    // Backpressure: two credits fill up, the third request waits for a pop.
    acc_q.delete(); pop_id_q.delete(); pop_data_q.delete();
    res_ready_i = 1'b0;
    drive(3'd1, 5'd1, 2'b00, 32'h0102_0304, 32'h0506_0708, 32'h0000_0010);
    req_valid_i = 1'b1;
    check("bp_ready_id1", 32'(req_ready_o), 32'd1);
    tick();
    drive(3'd2, 5'd2, 2'b10, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0000);
    check("bp_ready_id2", 32'(req_ready_o), 32'd1);
    tick();
    drive(3'd3, 5'd3, 2'b00, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0000);
    check("bp_ready_full", 32'(req_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 32'(res_valid_o), 32'd1);
      check("bp_hold_id", 32'(res_id_o), 32'd1);
      check("bp_hold_data", res_data_o, 32'h0000_0056);
      check("bp_hold_ready", 32'(req_ready_o), 32'd0);
    end
    res_ready_i = 1'b1;
    for (int i = 0; i < 30 && pop_id_q.size() < 3; i++) begin
      tick();
      if (acc_q.size() >= 3) req_valid_i = 1'b0;
    end
    req_valid_i = 1'b0;
    check("bp_accept_count", 32'(acc_q.size()), 32'd3);
    check("bp_pop_count", 32'(pop_id_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("bp_order_id", (i < pop_id_q.size()) ? pop_id_q[i] : 32'hDEAD_BEEF, 32'(i + 1));
    end
    check("bp_data0", (pop_data_q.size() > 0) ? pop_data_q[0] : 32'hDEAD_BEEF, 32'h0000_0056);
    check("bp_data1", (pop_data_q.size() > 1) ? pop_data_q[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("bp_data2", (pop_data_q.size() > 2) ? pop_data_q[2] : 32'hDEAD_BEEF, 32'h0000_03FC);
    $display("txn backpressure pops=%0d", pop_id_q.size());
    tick();
    check("bp_idle", 32'(busy_o), 32'd0);

    // Flush kills ids 4 and 5; id 6 presented alongside the flush is dropped.
    acc_q.delete(); pop_id_q.delete(); pop_data_q.delete();
    res_ready_i = 1'b1;
    drive(3'd4, 5'd4, 2'b00, 32'h0102_0304, 32'h0506_0708, 32'h0000_0010);
    req_valid_i = 1'b1;
    tick();
    drive(3'd5, 5'd5, 2'b00, 32'h0102_0304, 32'h0506_0708, 32'h0000_0010);
    tick();
    drive(3'd6, 5'd6, 2'b00, 32'h0102_0304, 32'h0506_0708, 32'h0000_0010);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    check("flush_res_valid", 32'(res_valid_o), 32'd0);
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_req_ready", 32'(req_ready_o), 32'd1);
    repeat (6) tick();
    check("flush_accepts", 32'(acc_q.size()), 32'd2);
    check("flush_no_result", 32'(pop_id_q.size()), 32'd0);
    $display("txn flush accepts=%0d pops=%0d", acc_q.size(), pop_id_q.size());

    // Asynchronous reset with two instructions in flight.
    acc_q.delete(); pop_id_q.delete(); pop_data_q.delete();
    drive(3'd1, 5'd1, 2'b00, 32'h0102_0304, 32'h0506_0708, 32'h0000_0010);
    req_valid_i = 1'b1;
    tick();
    drive(3'd2, 5'd2, 2'b00, 32'h0102_0304, 32'h0506_0708, 32'h0000_0010);
    tick();
    req_valid_i = 1'b0;
    check("mid_busy_before", 32'(busy_o), 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (6) tick();
    check("mid_no_stale", 32'(pop_id_q.size()), 32'd0);
    $display("txn reset_mid pops=%0d", pop_id_q.size());
    run_one("post_rst", 3'd7, 5'd31, 2'b10, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0000_0000, 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cvxif_mac_simd_unit.md
Name: cvxif_mac_simd_unit

Overview:
- Pipelined SIMD multiply-accumulate execution unit for the CV-X-IF coprocessor. It is the parametrised successor of the fixed 4x8-bit MAC4B instruction.
- Computes rd = rs3 + sum of lane-wise products of rs1 and rs2.
- Lane width (4x8 or 2x16) and signedness are selected per request.
- Sits behind the coprocessor decoder. It receives accepted issue requests with operands and returns results to the CV-X-IF result interface through an internal result FIFO with backpressure.

Parameters:
- XLEN, 32, operand/result width; fixed at 32 in this generation (lane layout depends on it).
- ID_WIDTH, 3, instruction id width (matches cvxif_pkg X_ID_WIDTH).
- PIPE_STAGES, 2, multiply/reduce pipeline depth; legal range 1..4.
- FIFO_DEPTH, 2, result FIFO entries; also the maximum number of in-flight plus buffered instructions; must be >= 1.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  kill all in-flight and buffered instructions
- req_valid_i  input  1  request valid
- req_ready_o  output  1  unit can accept a request
- req_id_i  input  ID_WIDTH  instruction id
- req_rd_i  input  5  destination register
- req_mode_i  input  2  bit0: 0 = 4x8 lanes, 1 = 2x16 lanes; bit1: 1 = signed, 0 = unsigned
- req_rs1_i  input  XLEN  multiplicand vector
- req_rs2_i  input  XLEN  multiplier vector
- req_rs3_i  input  XLEN  accumulator addend
- res_valid_o  output  1  result valid
- res_ready_i  input  1  result consumed
- res_id_o  output  ID_WIDTH  result id
- res_rd_o  output  5  result destination register
- res_data_o  output  XLEN  result value
- busy_o  output  1  any instruction in pipeline or FIFO

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Pipeline valids, FIFO pointers and credit counter all cleared.
  - res_valid_o=0, res_id_o=0, res_rd_o=0, res_data_o=0, busy_o=0, req_ready_o=1 in the first cycle after reset release.
- Accept: handshake when req_valid_i && req_ready_o at a rising edge. Operands, id, rd and mode are captured into stage 0.
- Credit counter:
  - Counts instructions in the pipeline plus instructions in the FIFO.
  - req_ready_o = (count < FIFO_DEPTH); purely registered-state based, no combinational path from res_ready_i.
  - Same-cycle accept and pop leave count unchanged.
- Pipeline:
  - Advances unconditionally; credit gating guarantees a FIFO slot on exit.
  - Result is written into the FIFO at the edge PIPE_STAGES cycles after the accept edge.
- FIFO:
  - First-word-fall-through: res_valid_o rises in the cycle after that write when the FIFO was empty.
  - Total latency: accept edge to res_valid_o high = PIPE_STAGES cycles.
- Pop: res_valid_o && res_ready_i. Results are returned strictly in issue order.
- Stability: res_* holds stable while res_valid_o && !res_ready_i.
- Arithmetic, 4x8:
  - Lanes i=0..3 use bits [8i+7:8i].
  - Each operand is sign- or zero-extended per mode bit1, giving 16-bit products.
- Arithmetic, 2x16:
  - Lanes i=0..1 use bits [16i+15:16i], giving 32-bit products.
- Sum: products are extended to 34 bits and summed with the extended rs3.
  - Without saturation, the result is the low 32 bits (wrap mod 2^32).
- Flush: flush_i high at an edge clears all pipeline valids, the FIFO and the credit counter.
  - res_valid_o=0 in the next cycle.
  - A request presented in the same cycle as flush_i is dropped, not accepted.
- Boundary cases:
  - FIFO full with pop and accept in the same cycle: legal only if count < FIFO_DEPTH, which the credit rule enforces.
  - FIFO pointers wrap modulo FIFO_DEPTH (non-power-of-2 depths supported).
- busy_o = (count != 0).
- Reset mid-operation discards everything; no result is emitted afterwards.

Optional Feature:
- Macro CVXIF_MAC_SAT_EN.
- When defined, the final 34-bit sum is clamped:
  - Signed mode: range [0x80000000, 0x7FFFFFFF].
  - Unsigned mode: maximum 0xFFFFFFFF (minimum 0).
- When undefined, results wrap modulo 2^32 and no clamp logic is synthesised.
- Latency is identical in both cases.

Test Plan:
- 4x8 unsigned: rs1=0x01020304, rs2=0x05060708, rs3=0x10, id=1 -> res_data_o=0x00000056, res_id_o=1, res_valid_o exactly PIPE_STAGES cycles after accept.
- 4x8 signed: rs1=0xFFFFFFFF, rs2=0x01010101, rs3=0 -> 0xFFFFFFFC. The same operands in unsigned mode -> 0x000003FC.
- 2x16 signed: rs1=rs2=0x7FFF7FFF, rs3=0x7FFFFFFF -> 0xFFFE0001 without CVXIF_MAC_SAT_EN, 0x7FFFFFFF with it.
- Backpressure: res_ready_i=0, FIFO_DEPTH=2, three back-to-back requests (ids 1, 2, 3):
  - Ids 1 and 2 accepted; req_ready_o=0 thereafter.
  - Raise res_ready_i: pop id 1, then id 3 is accepted; results emerge in order 1, 2, 3.
- Flush: issue ids 4 and 5, assert flush_i one cycle after accepting id 5 -> no res_valid_o for either, busy_o=0 and req_ready_o=1 on the next cycle.
- Reset mid-stream: deassert rst_ni with 2 instructions in flight -> all outputs go to their reset values asynchronously; after release, no stale result appears and a new request completes normally.
